// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared widths, pc_src encodings, instruction field positions
//                and fetch state encodings for the fetch stage and for the
//                branch-resolution logic that reuses next_pc_target.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Datapath and field widths
    localparam int W_CPU    = 32;
    localparam int W_IMM    = 16;
    localparam int W_JADDR  = 26;
    localparam int W_PC_SRC = 2;

    // Redirect kinds carried on pc_src
    localparam logic [W_PC_SRC-1:0] PC_SRC_NEXT = 2'd0;
    localparam logic [W_PC_SRC-1:0] PC_SRC_BRCH = 2'd1;
    localparam logic [W_PC_SRC-1:0] PC_SRC_JUMP = 2'd2;
    localparam logic [W_PC_SRC-1:0] PC_SRC_REGF = 2'd3;

    // Instruction word field positions (used by decode and branch resolution)
    localparam int FLD_OP_HI    = 31;
    localparam int FLD_OP_LO    = 26;
    localparam int FLD_IMM_HI   = 15;
    localparam int FLD_IMM_LO   = 0;
    localparam int FLD_JADDR_HI = 25;
    localparam int FLD_JADDR_LO = 0;

    // Fetch state encodings
    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_VALID = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_t;

    // Word offset -> byte offset, sign extended to the datapath width
    function automatic logic [W_CPU-1:0] sext_imm_words(input logic [W_IMM-1:0] imm);
        return {{(W_CPU-W_IMM-2){imm[W_IMM-1]}}, imm, 2'b00};
    endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/next_pc_target.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_target
//  Description : Combinational control-flow target calculator.
//                  BRCH : br_base + sign_ext(br_imm) * 4
//                  JUMP : {br_base[31:28], jaddr, 2'b00}
//                  REGF : {reg_target[31:2], 2'b00}
//                  NEXT : don't care (br_base passed through)
//  Ports       : pc_src, br_base, br_imm, jaddr, reg_target -> target
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_target
    import fetch_unit_pkg::*;
(
    input  logic [W_PC_SRC-1:0] pc_src,
    input  logic [W_CPU-1:0]    br_base,
    input  logic [W_IMM-1:0]    br_imm,
    input  logic [W_JADDR-1:0]  jaddr,
    input  logic [W_CPU-1:0]    reg_target,
    output logic [W_CPU-1:0]    target
);

    // Register targets are forced word aligned, so the low bits never matter
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^reg_target[1:0];

    always_comb begin
        target = br_base;
        case (pc_src)
            PC_SRC_BRCH: target = br_base + sext_imm_words(br_imm);
            PC_SRC_JUMP: target = {br_base[W_CPU-1 -: (W_CPU-W_JADDR-2)], jaddr, 2'b00};
            PC_SRC_REGF: target = {reg_target[W_CPU-1:2], 2'b00};
            default:     target = br_base;
        endcase
    end

endmodule : next_pc_target
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the PC, issues word reads over
//                a req/ack handshake (one outstanding request), holds a
//                single-entry {inst, inst_pc} register towards decode and
//                applies branch / jump / register-jump redirects.
//  Ports       : clk, rst (sync, active high)
//                imem_req/imem_addr/imem_ack/imem_rdata  - instruction memory
//                inst/inst_pc/inst_valid/inst_ready      - decode handshake
//                redirect/pc_src/br_base/br_imm/jaddr/reg_target - redirect
//                fetch_count/squash_count - only when FETCH_PERF_EN defined
//  Options     : FETCH_PERF_EN - adds delivered / squashed instruction
//                counters (32-bit, wrapping)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int               W_CPU    = fetch_unit_pkg::W_CPU,
    parameter logic [W_CPU-1:0] RESET_PC = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic                                imem_req,
    output logic [W_CPU-1:0]                    imem_addr,
    input  logic                                imem_ack,
    input  logic [W_CPU-1:0]                    imem_rdata,
    output logic [W_CPU-1:0]                    inst,
    output logic [W_CPU-1:0]                    inst_pc,
    output logic                                inst_valid,
    input  logic                                inst_ready,
    input  logic                                redirect,
    input  logic [fetch_unit_pkg::W_PC_SRC-1:0] pc_src,
    input  logic [W_CPU-1:0]                    br_base,
    input  logic [fetch_unit_pkg::W_IMM-1:0]    br_imm,
    input  logic [fetch_unit_pkg::W_JADDR-1:0]  jaddr,
    input  logic [W_CPU-1:0]                    reg_target
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                         fetch_count,
    output logic [31:0]                         squash_count
`endif
);
    import fetch_unit_pkg::*;

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [W_CPU-1:0] r_pc;
    logic [W_CPU-1:0] r_pending;
    logic [W_CPU-1:0] r_inst;
    logic [W_CPU-1:0] r_inst_pc;
    logic [W_CPU-1:0] w_target;
    logic [W_CPU-1:0] w_pc_nxt;
    logic             w_redir;
    logic             w_req;
    logic             w_pc_load;
    logic             w_pend_load;
    logic             w_deliver;
    logic             w_squash;

    next_pc_target u_target (
        .pc_src     (pc_src),
        .br_base    (br_base),
        .br_imm     (br_imm),
        .jaddr      (jaddr),
        .reg_target (reg_target),
        .target     (w_target)
    );

    // A NEXT-kind redirect is a no-op everywhere
    assign w_redir = redirect && (pc_src != PC_SRC_NEXT);

    // The address is simply the PC: a redirect during an outstanding request
    // parks its target in r_pending instead of touching r_pc, so the
    // address stays stable until the memory acknowledges.
    assign w_req      = (r_state != FS_VALID) && !rst;
    assign imem_req   = w_req;
    assign imem_addr  = r_pc;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = (r_state == FS_VALID);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FS_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes. Redirect outranks both ack and ready.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pc_load   = 1'b0;
        w_pend_load = 1'b0;
        w_deliver   = 1'b0;
        w_squash    = 1'b0;
        case (r_state)
            FS_FETCH: begin
                if (imem_ack) begin
                    w_pc_load = 1'b1;
                    if (w_redir) begin
                        // Returning word belongs to the abandoned path
                        w_pc_nxt = w_target;
                        w_squash = 1'b1;
                    end else begin
                        w_pc_nxt    = r_pc + W_CPU'(4);
                        w_deliver   = 1'b1;
                        w_state_nxt = FS_VALID;
                    end
                end else if (w_redir) begin
                    w_pend_load = 1'b1;
                    w_state_nxt = FS_DRAIN;
                end
            end
            FS_VALID: begin
                if (w_redir) begin
                    w_pc_nxt    = w_target;
                    w_pc_load   = 1'b1;
                    w_squash    = 1'b1;
                    w_state_nxt = FS_FETCH;
                end else if (inst_ready) begin
                    w_state_nxt = FS_FETCH;
                end
            end
            FS_DRAIN: begin
                if (imem_ack) begin
                    // A redirect landing on the ack cycle is the newest target
                    w_pc_nxt    = w_redir ? w_target : r_pending;
                    w_pc_load   = 1'b1;
                    w_squash    = 1'b1;
                    w_state_nxt = FS_FETCH;
                end else if (w_redir) begin
                    w_pend_load = 1'b1;
                end
            end
            default: begin
                w_state_nxt = FS_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_pending <= '0;
            r_inst    <= '0;
            r_inst_pc <= '0;
        end else begin
            if (w_pc_load) begin
                r_pc <= w_pc_nxt;
            end
            if (w_pend_load) begin
                r_pending <= w_target;
            end
            if (w_deliver) begin
                r_inst    <= imem_rdata;
                r_inst_pc <= r_pc;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_squash_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count  <= '0;
            r_squash_count <= '0;
        end else begin
            if (w_deliver) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_squash) begin
                r_squash_count <= r_squash_count + 32'd1;
            end
        end
    end

    assign fetch_count  = r_fetch_count;
    assign squash_count = r_squash_count;
`endif

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: directed sequences,
//                a redirect-target vector table and a randomized run against
//                a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_salt     = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [1:0]  pc_src;
    logic [31:0] br_base;
    logic [15:0] br_imm;
    logic [25:0] jaddr;
    logic [31:0] reg_target;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] squash_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory returns a recognisable function of the address
    assign imem_rdata = imem_addr ^ c_salt;

    fetch_unit #(.W_CPU(32), .RESET_PC(c_reset_pc)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .redirect   (redirect),
        .pc_src     (pc_src),
        .br_base    (br_base),
        .br_imm     (br_imm),
        .jaddr      (jaddr),
        .reg_target (reg_target)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count  (fetch_count),
        .squash_count (squash_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Target rule from the redirect definitions, in plain arithmetic
    function automatic logic [31:0] ref_target(input logic [1:0] src, input logic [31:0] base,
                                               input logic [15:0] imm, input logic [25:0] ja,
                                               input logic [31:0] rt);
        int          simm;
        logic [31:0] jw;
        simm = int'($signed(imm));
        jw   = {6'd0, ja};
        case (src)
            2'd1:    return base + 32'(simm * 4);
            2'd2:    return (base & 32'hF000_0000) | (jw * 32'd4);
            2'd3:    return rt & ~32'd3;
            default: return base;
        endcase
    endfunction

    task automatic clear_redirect();
        redirect = 1'b0; pc_src = 2'd0; br_base = '0; br_imm = '0; jaddr = '0; reg_target = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_redirect();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for an instruction to sit in the output register
    task automatic go_valid();
        for (int k = 0; k < 20 && !inst_valid; k++) @(negedge clk);
        chk("go_valid_timeout", {31'd0, inst_valid}, 32'd1);
    endtask

    typedef struct {
        logic [1:0]  pc_src;
        logic [31:0] br_base;
        logic [15:0] br_imm;
        logic [25:0] jaddr;
        logic [31:0] reg_target;
        logic        squash;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[7];

    // Reference model state
    logic        m_buf_v;
    logic [31:0] m_buf_pc;
    logic [31:0] m_next;
    logic [31:0] m_cur;
    logic        m_active;
    logic        m_tainted;
    logic [31:0] m_fetch;
    logic [31:0] m_squash;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved_pc;
        logic [31:0] saved_inst;
        logic [31:0] tgt;
        logic        redir;

        vecs[0] = '{2'd1, 32'h0000_0020, 16'hFFFC, 26'h0,       32'h0,         1'b1, 32'h0000_0010};
        vecs[1] = '{2'd2, 32'h1000_0008, 16'h0,    26'h40,      32'h0,         1'b1, 32'h1000_0100};
        vecs[2] = '{2'd3, 32'h0,         16'h0,    26'h0,       32'h0000_0047, 1'b1, 32'h0000_0044};
        vecs[3] = '{2'd1, 32'h0000_0100, 16'h0010, 26'h0,       32'h0,         1'b1, 32'h0000_0140};
        vecs[4] = '{2'd2, 32'hF000_0000, 16'h0,    26'h3FF_FFFF, 32'h0,        1'b1, 32'hFFFF_FFFC};
        vecs[5] = '{2'd1, 32'h0,         16'h8000, 26'h0,       32'h0,         1'b1, 32'hFFFE_0000};
        vecs[6] = '{2'd0, 32'h0000_0020, 16'hFFFC, 26'h40,      32'h0000_0047, 1'b0, 32'h0};

        rst = 1'b1; imem_ack = 1'b1; inst_ready = 1'b1;
        clear_redirect();

        // ---- Reset state, then zero-latency streaming ----
        @(negedge clk);
        @(negedge clk);
        chk("rst_req",   {31'd0, imem_req},   32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst",  inst,    32'd0);
        chk("rst_pc",    inst_pc, 32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_fcnt", fetch_count,  32'd0);
        chk("rst_scnt", squash_count, 32'd0);
`endif
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("stream_valid", {31'd0, inst_valid}, (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) begin
                chk("stream_pc",   inst_pc, 32'(k / 2 * 4));
                chk("stream_inst", inst,    32'(k / 2 * 4) ^ c_salt);
            end
        end

        // ---- Decode stalls: output held, no request, pc parked ----
        inst_ready = 1'b0;
        @(negedge clk);
        chk("stall_first_pc", inst_pc, 32'h0000_000C);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_pc",    inst_pc, 32'h0000_000C);
            chk("stall_inst",  inst,    32'h0000_000C ^ c_salt);
            chk("stall_req",   {31'd0, imem_req}, 32'd0);
            chk("stall_addr",  imem_addr, 32'h0000_0010);
        end

        // ---- 3-cycle memory, JUMP redirect on the first wait cycle ----
        imem_ack = 1'b0; inst_ready = 1'b1;
        @(negedge clk);
        chk("drain_a_addr", imem_addr, 32'h0000_0010);
        redirect = 1'b1; pc_src = 2'd2; br_base = 32'h1000_0008; jaddr = 26'h40;
        @(negedge clk);
        clear_redirect();
        chk("drain_b_req",  {31'd0, imem_req}, 32'd1);
        chk("drain_b_addr", imem_addr, 32'h0000_0010);
        @(negedge clk);
        chk("drain_c_addr", imem_addr, 32'h0000_0010);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("drain_d_valid", {31'd0, inst_valid}, 32'd0);
        chk("drain_d_addr",  imem_addr, 32'h1000_0100);
        imem_ack = 1'b1; inst_ready = 1'b0;
        @(negedge clk);
        chk("drain_e_valid", {31'd0, inst_valid}, 32'd1);
        chk("drain_e_pc",    inst_pc, 32'h1000_0100);
        chk("drain_e_inst",  inst,    32'hB5A5_0100);

        // ---- Redirect table, each applied while an instruction is buffered ----
        for (int v = 0; v < 7; v++) begin
            imem_ack = 1'b1; inst_ready = 1'b0;
            go_valid();
            saved_pc = inst_pc;
            saved_inst = inst;
            @(negedge clk);
            redirect = 1'b1; pc_src = vecs[v].pc_src; br_base = vecs[v].br_base;
            br_imm = vecs[v].br_imm; jaddr = vecs[v].jaddr; reg_target = vecs[v].reg_target;
            @(negedge clk);
            clear_redirect();
            if (vecs[v].squash) begin
                chk($sformatf("vec%0d_valid", v), {31'd0, inst_valid}, 32'd0);
                chk($sformatf("vec%0d_addr", v), imem_addr, vecs[v].exp_addr);
            end else begin
                chk($sformatf("vec%0d_valid", v), {31'd0, inst_valid}, 32'd1);
                chk($sformatf("vec%0d_pc", v), inst_pc, saved_pc);
                chk($sformatf("vec%0d_inst", v), inst, saved_inst);
                chk($sformatf("vec%0d_addr", v), imem_addr, saved_pc + 32'd4);
            end
        end

        // ---- PC wrap from the top word to zero ----
        go_valid();
        @(negedge clk);
        redirect = 1'b1; pc_src = 2'd3; reg_target = 32'hFFFF_FFFF;
        @(negedge clk);
        clear_redirect();
        go_valid();
        chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        chk("wrap_addr", imem_addr, 32'h0);
        go_valid();
        chk("wrap_next_pc", inst_pc, 32'h0);

        // ---- Reset while draining; ack arriving during reset is ignored ----
        imem_ack = 1'b0; inst_ready = 1'b1;
        @(negedge clk);
        chk("rd_fetch_addr", imem_addr, 32'h4);
        redirect = 1'b1; pc_src = 2'd1; br_base = 32'h0000_8000; br_imm = 16'h0100;
        @(negedge clk);
        clear_redirect();
        chk("rd_drain_addr", imem_addr, 32'h4);
        rst = 1'b1; imem_ack = 1'b1;
        @(negedge clk);
        chk("rd_req",   {31'd0, imem_req},   32'd0);
        chk("rd_valid", {31'd0, inst_valid}, 32'd0);
        chk("rd_inst_pc", inst_pc, 32'd0);
`ifdef FETCH_PERF_EN
        chk("rd_fcnt", fetch_count,  32'd0);
        chk("rd_scnt", squash_count, 32'd0);
`endif
        rst = 1'b0; imem_ack = 1'b0;
        @(negedge clk);
        chk("rd_post_req",   {31'd0, imem_req}, 32'd1);
        chk("rd_post_addr",  imem_addr, c_reset_pc);
        chk("rd_post_valid", {31'd0, inst_valid}, 32'd0);
        imem_ack = 1'b1;
        @(negedge clk);
        chk("rd_first_pc", inst_pc, c_reset_pc);

        // ---- Randomized run against the transaction-level model ----
        do_reset();
        m_buf_v = 1'b0; m_buf_pc = '0; m_next = c_reset_pc; m_cur = '0;
        m_active = 1'b0; m_tainted = 1'b0; m_fetch = '0; m_squash = '0;
        for (int c = 0; c < 2000; c++) begin
            imem_ack   = ($urandom_range(0, 1) == 1);
            inst_ready = ($urandom_range(0, 9) < 6);
            redirect   = ($urandom_range(0, 5) == 0);
            pc_src     = 2'($urandom_range(0, 3));
            br_base    = $urandom;
            br_imm     = 16'($urandom);
            jaddr      = 26'($urandom);
            reg_target = $urandom;
            #1;
            if (!m_buf_v && !m_active) begin
                m_cur = m_next;
                m_active = 1'b1;
            end
            chk("rnd_req",   {31'd0, imem_req},   {31'd0, !m_buf_v});
            chk("rnd_valid", {31'd0, inst_valid}, {31'd0, m_buf_v});
            if (!m_buf_v) chk("rnd_addr", imem_addr, m_cur);
            if (m_buf_v) begin
                chk("rnd_pc",   inst_pc, m_buf_pc);
                chk("rnd_inst", inst,    m_buf_pc ^ c_salt);
            end
`ifdef FETCH_PERF_EN
            chk("rnd_fcnt", fetch_count,  m_fetch);
            chk("rnd_scnt", squash_count, m_squash);
`endif
            redir = redirect && (pc_src != 2'd0);
            tgt   = ref_target(pc_src, br_base, br_imm, jaddr, reg_target);
            if (m_buf_v) begin
                if (redir) begin
                    m_buf_v = 1'b0; m_next = tgt; m_squash++;
                end else if (inst_ready) begin
                    m_buf_v = 1'b0;
                end
            end else if (imem_ack) begin
                if (redir) begin
                    m_next = tgt; m_squash++;
                end else if (m_tainted) begin
                    m_squash++;
                end else begin
                    m_buf_v = 1'b1; m_buf_pc = m_cur; m_next = m_cur + 32'd4; m_fetch++;
                end
                m_tainted = 1'b0;
                m_active  = 1'b0;
            end else if (redir) begin
                m_next = tgt; m_tainted = 1'b1;
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
